// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller and its
// register scoreboard.
package hazard_ctrl_pkg;

   localparam int REG_AW      = 6;
   localparam int FP_BIT      = 5;
   localparam int NUM_REGS    = 64;
   localparam int MAX_OUT_DEF = 4;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HAZ   = 2'd1,
      MEMW  = 2'd2,
      FLUSH = 2'd3
   } hz_state_e;

   // x0 is hardwired zero; f0 (FP bit set) is an ordinary register.
   function automatic logic is_x0(input logic [REG_AW-1:0] addr);
      return (addr[FP_BIT] == 1'b0) && (addr[FP_BIT-1:0] == 5'd0);
   endfunction

   function automatic logic [NUM_REGS-1:0] addr_mask(input logic [REG_AW-1:0] addr);
      logic [NUM_REGS-1:0] m;
      m       = {NUM_REGS{1'b0}};
      m[addr] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard_regs.sv
// Pending-write scoreboard: one bit per architectural register, with the
// writeback clear visible to the same-cycle lookups.
module scoreboard_regs
   import hazard_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic [REG_AW-1:0] rd_addr,
   output logic              rs1_pend,
   output logic              rs2_pend,
   output logic              rd_pend
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] visible;

   // Apply the writeback clear before lookup; a set of the same address wins.
   always_comb begin
      clr_mask = {NUM_REGS{1'b0}};
      set_mask = {NUM_REGS{1'b0}};
      if (clr_en) begin
         clr_mask = addr_mask(clr_addr);
      end else begin
         clr_mask = {NUM_REGS{1'b0}};
      end
      if (set_en && !is_x0(set_addr)) begin
         set_mask = addr_mask(set_addr);
      end else begin
         set_mask = {NUM_REGS{1'b0}};
      end
      visible      = pending_q & ~clr_mask;
      visible[0]   = 1'b0;
      pending_d    = visible | set_mask;
      pending_d[0] = 1'b0;
      rs1_pend     = visible[rs1_addr];
      rs2_pend     = visible[rs2_addr];
      rd_pend      = visible[rd_addr];
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= {NUM_REGS{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: register scoreboard, long-op credit counter and
// the stall/flush sequencing FSM.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MAX_OUT = MAX_OUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_wr_rd,
   input  logic              id_long,
   input  logic              wb_valid,
   input  logic              wb_long,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              branch_taken,
   input  logic              dmem_stall,
   output logic              issue,
   output logic              stall_if,
   output logic              stall_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              err
);

   hz_state_e        state_q, state_d, cause;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             err_q, err_d;
   logic             rs1_pend, rs2_pend, rd_pend;
   logic             wb_long_ret, at_max, hazard;
   logic             cnt_inc, cnt_dec, set_en;

   scoreboard_regs u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (set_en),
      .set_addr (id_rd_addr),
      .clr_en   (wb_valid),
      .clr_addr (wb_rd_addr),
      .rs1_addr (id_rs1_addr),
      .rs2_addr (id_rs2_addr),
      .rd_addr  (id_rd_addr),
      .rs1_pend (rs1_pend),
      .rs2_pend (rs2_pend),
      .rd_pend  (rd_pend)
   );

   // Hazard detection, next-state selection and output decode.
   always_comb begin
      wb_long_ret = wb_valid & wb_long;
      at_max      = (out_cnt_q == CNT_W'(MAX_OUT));
      hazard      = id_valid & ((id_use_rs1 & rs1_pend) |
                                (id_use_rs2 & rs2_pend) |
                                (id_wr_rd   & rd_pend)  |
                                (id_long & at_max & ~wb_long_ret));
      if (dmem_stall) begin
         cause = MEMW;
      end else if (branch_taken) begin
         cause = FLUSH;
      end else if (hazard) begin
         cause = HAZ;
      end else begin
         cause = RUN;
      end

      state_d = cause;
      case (state_q)
         RUN:     state_d = cause;
         HAZ:     state_d = cause;
         MEMW:    state_d = dmem_stall ? MEMW : cause;
         FLUSH:   state_d = cause;
         default: state_d = RUN;
      endcase
      if (rst) begin
         state_d = RUN;
      end else begin
         state_d = state_d;
      end

      issue       = 1'b0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (!rst) begin
         case (state_d)
            RUN: issue = id_valid;
            HAZ: begin
               stall_if    = 1'b1;
               stall_id    = 1'b1;
               flush_id_ex = 1'b1;
            end
            MEMW: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end
            FLUSH: begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
            default: issue = 1'b0;
         endcase
      end else begin
         issue = 1'b0;
      end

      set_en = issue & id_long & id_wr_rd;
   end

   // Outstanding long-op counter and sticky underflow flag.
   always_comb begin
      cnt_inc   = issue & id_long;
      cnt_dec   = wb_long_ret & (out_cnt_q != {CNT_W{1'b0}});
      out_cnt_d = out_cnt_q;
      case ({cnt_inc, cnt_dec})
         2'b10:   out_cnt_d = at_max ? out_cnt_q : (out_cnt_q + 3'd1);
         2'b01:   out_cnt_d = out_cnt_q - 3'd1;
         default: out_cnt_d = out_cnt_q;
      endcase
      err_d = err_q | (wb_long_ret & (out_cnt_q == {CNT_W{1'b0}}));
   end

   // State, counter and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         out_cnt_q <= {CNT_W{1'b0}};
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
      end
   end

   assign out_cnt = out_cnt_q;
   assign err     = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model queues expected outputs
// per cycle, which are popped and compared against the DUT.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2, id_wr_rd, id_long;
   logic [5:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
   logic       wb_valid, wb_long, branch_taken, dmem_stall;
   logic       issue, stall_if, stall_id, flush_if_id, flush_id_ex, err;
   logic [2:0] out_cnt;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_rd(id_wr_rd),
      .id_long(id_long), .wb_valid(wb_valid), .wb_long(wb_long), .wb_rd_addr(wb_rd_addr),
      .branch_taken(branch_taken), .dmem_stall(dmem_stall), .issue(issue),
      .stall_if(stall_if), .stall_id(stall_id), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .out_cnt(out_cnt), .err(err)
   );

   typedef struct packed {
      logic        issue, sif, sid, fifid, fidex;
      logic [2:0]  cnt;
      logic        err;
      logic [1:0]  st;
      logic [63:0] pend;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] m_pend = 64'd0;
   logic [2:0]  m_cnt  = 3'd0;
   logic        m_err  = 1'b0;
   hz_state_e   m_st   = RUN;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   function automatic logic pe(input logic [5:0] a);
      return (a != 6'd0) && m_pend[a] && !(wb_valid && (wb_rd_addr == a));
   endfunction

   task automatic idle();
      id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wr_rd = 1'b0; id_long = 1'b0;
      id_rs1_addr = 6'd0; id_rs2_addr = 6'd0; id_rd_addr = 6'd0;
      wb_valid = 1'b0; wb_long = 1'b0; wb_rd_addr = 6'd0;
      branch_taken = 1'b0; dmem_stall = 1'b0;
   endtask

   task automatic id(input logic [5:0] rs1, input logic u1, input logic [5:0] rs2, input logic u2,
                     input logic [5:0] rd, input logic w, input logic lng);
      id_valid = 1'b1; id_rs1_addr = rs1; id_use_rs1 = u1; id_rs2_addr = rs2; id_use_rs2 = u2;
      id_rd_addr = rd; id_wr_rd = w; id_long = lng;
   endtask

   task automatic wb(input logic [5:0] rd, input logic lng);
      wb_valid = 1'b1; wb_rd_addr = rd; wb_long = lng;
   endtask

   // One clock: model predicts, queue the prediction, compare, then advance the model.
   task automatic cycle();
      exp_t      e, o;
      logic      haz, iss, inc, dec;
      hz_state_e ns;
      #1;
      haz = id_valid && ((id_use_rs1 && pe(id_rs1_addr)) || (id_use_rs2 && pe(id_rs2_addr)) ||
                         (id_wr_rd && pe(id_rd_addr)) ||
                         (id_long && (m_cnt == 3'd4) && !(wb_valid && wb_long)));
      e = '0;
      e.cnt = m_cnt; e.err = m_err; e.st = m_st; e.pend = m_pend;
      if (rst) ns = RUN;
      else if (dmem_stall) begin ns = MEMW; e.sif = 1'b1; e.sid = 1'b1; end
      else if (branch_taken) begin ns = FLUSH; e.fifid = 1'b1; e.fidex = 1'b1; end
      else if (haz) begin ns = HAZ; e.sif = 1'b1; e.sid = 1'b1; e.fidex = 1'b1; end
      else begin ns = RUN; e.issue = id_valid; end
      iss = e.issue;
      sb_q.push_back(e);
      #1;
      o = sb_q.pop_front();
      chk("issue", issue, o.issue);
      chk("stall_if", stall_if, o.sif);
      chk("stall_id", stall_id, o.sid);
      chk("flush_if_id", flush_if_id, o.fifid);
      chk("flush_id_ex", flush_id_ex, o.fidex);
      chk("out_cnt", out_cnt, o.cnt);
      chk("err", err, o.err);
      chk("state", dut.state_q, o.st);
      chk("pending", dut.u_sb.pending_q, o.pend);
      @(posedge clk);
      if (rst) begin
         m_pend = 64'd0; m_cnt = 3'd0; m_err = 1'b0; m_st = RUN;
      end else begin
         if (wb_valid) m_pend[wb_rd_addr] = 1'b0;
         if (iss && id_long && id_wr_rd && id_rd_addr != 6'd0) m_pend[id_rd_addr] = 1'b1;
         inc = iss && id_long;
         dec = wb_valid && wb_long && (m_cnt != 3'd0);
         if (wb_valid && wb_long && m_cnt == 3'd0) m_err = 1'b1;
         if (inc && !dec && m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
         else if (dec && !inc) m_cnt = m_cnt - 3'd1;
         m_st = ns;
      end
      @(negedge clk);
   endtask

   logic [5:0] pool [8] = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd32, 6'd33, 6'd37, 6'd63};

   initial begin
      rst = 1'b1; idle();
      @(posedge clk); @(negedge clk);
      cycle();
      rst = 1'b0;
      // Load-use on x5, released in the writeback cycle itself.
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1); cycle();
      idle(); id(6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1, 1'b0); cycle(); cycle();
      chk("033_held", issue, 1'b0);
      wb(6'd5, 1'b1); cycle();
      // FLW f3 does not block an integer read of x3.
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd35, 1'b1, 1'b1); cycle();
      idle(); id(6'd0, 1'b0, 6'd3, 1'b1, 6'd7, 1'b1, 1'b0); cycle();
      idle(); wb(6'd35, 1'b1); cycle();
      // x0 never pends; f0 does.
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1); cycle();
      idle(); id(6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0); cycle();
      idle(); wb(6'd0, 1'b1); cycle();
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd32, 1'b1, 1'b1); cycle();
      idle(); id(6'd32, 1'b1, 6'd0, 1'b0, 6'd1, 1'b1, 1'b0); cycle();
      idle(); wb(6'd32, 1'b1); cycle();
      // Set and clear of the same address in one cycle leaves it set.
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd13, 1'b1, 1'b1); wb(6'd13, 1'b0); cycle();
      chk("setclr_bit", dut.u_sb.pending_q[13], 1'b1);
      idle(); id(6'd13, 1'b1, 6'd0, 1'b0, 6'd2, 1'b1, 1'b0); cycle();
      idle(); wb(6'd13, 1'b1); cycle();
      // Credit limit: four outstanding, fifth waits, released by a same-cycle wb_long.
      for (int i = 0; i < 4; i++) begin
         idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'(8 + i), 1'b1, 1'b1); cycle();
      end
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1, 1'b1); cycle(); cycle();
      wb(6'd8, 1'b1); cycle();
      idle(); cycle();
      chk("035_cnt", out_cnt, 3'd4);
      // Branch while a hazard is pending.
      idle(); id(6'd9, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0); branch_taken = 1'b1; cycle();
      idle(); cycle();
      // Memory stall overrides a waiting branch; flush follows the stall.
      for (int i = 0; i < 3; i++) begin
         idle(); id(6'd1, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0); dmem_stall = 1'b1; branch_taken = 1'b1; cycle();
      end
      idle(); id(6'd1, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0); branch_taken = 1'b1; cycle();
      idle(); cycle();
      for (int i = 9; i < 13; i++) begin
         idle(); wb(6'(i), 1'b1); cycle();
      end
      // Reset in the middle of a memory stall with two ops outstanding.
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd20, 1'b1, 1'b1); cycle();
      idle(); id(6'd0, 1'b0, 6'd0, 1'b0, 6'd21, 1'b1, 1'b1); cycle();
      idle(); id(6'd20, 1'b1, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0); dmem_stall = 1'b1; cycle();
      chk("038_cnt_before", out_cnt, 3'd2);
      rst = 1'b1; cycle();
      rst = 1'b0; idle(); cycle();
      idle(); wb(6'd20, 1'b1); cycle();
      idle(); cycle();
      chk("038_err", err, 1'b1);
      // Constrained random traffic.
      for (int n = 0; n < 400; n++) begin
         idle();
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) != 0)
            id(pool[$urandom_range(0, 7)], 1'($urandom), pool[$urandom_range(0, 7)], 1'($urandom),
               pool[$urandom_range(0, 7)], 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) wb(pool[$urandom_range(0, 7)], 1'($urandom));
         branch_taken = ($urandom_range(0, 9) == 0);
         dmem_stall   = ($urandom_range(0, 7) == 0);
         cycle();
      end
      rst = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_OUT, default 4: maximum outstanding long-latency writes.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 id_valid  in  1  ID stage holds a decoded instruction.
REQ-005 id_rs1_addr, id_rs2_addr, id_rd_addr  in  6 each  decoded register addresses; bit 5 = FP file, bits 4:0 = index.
REQ-006 id_use_rs1, id_use_rs2, id_wr_rd  in  1 each  instruction reads rs1 / reads rs2 / writes rd.
REQ-007 id_long  in  1  instruction is long-latency (LOAD, FLW, multi-cycle FALU).
REQ-008 wb_valid, wb_long  in  1 each  writeback occurring / writeback retires a long op.
REQ-009 wb_rd_addr  in  6  writeback destination.
REQ-010 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-011 dmem_stall  in  1  data memory not ready; whole pipe freezes.
REQ-012 issue  out  1  ID instruction advances to EX this cycle.
REQ-013 stall_if, stall_id  out  1 each  hold PC and IF/ID register.
REQ-014 flush_if_id, flush_id_ex  out  1 each  insert bubble into the named pipe register.
REQ-015 out_cnt  out  3  outstanding long-op count.
REQ-016 err  out  1  sticky: wb_long received with out_cnt==0.

Function
REQ-017 Pending vector: 64 bits, one per address; bit 0 (x0) SHALL read 0 always; bit 32 (f0) is an ordinary register.
REQ-018 Clear mask: when wb_valid=1, pending[wb_rd_addr] clears at the next edge; the hazard check SHALL use pending with the same-cycle clear already applied (WB-to-ID bypass).
REQ-019 Hazard = id_valid & ((id_use_rs1 & pend[rs1]) | (id_use_rs2 & pend[rs2]) | (id_wr_rd & pend[rd]) | (id_long & out_cnt==MAX_OUT & ~wb_long)).
REQ-020 issue = id_valid & ~hazard & ~dmem_stall & ~branch_taken; combinational, zero latency.
REQ-021 On issue with id_long & id_wr_rd & rd!=0, pending[rd] sets at the next edge; a set and a clear of the same address in one cycle SHALL leave the bit set.
REQ-022 out_cnt: +1 on issue of an id_long instruction, -1 on wb_valid&wb_long; both in one cycle leaves it unchanged; never exceeds MAX_OUT; never underflows (err sets instead).
REQ-023 FSM states RUN, HAZ, MEMW, FLUSH; priority dmem_stall > branch_taken > hazard.
REQ-024 RUN->MEMW on dmem_stall; RUN->FLUSH on branch_taken; RUN->HAZ on hazard; each returns to RUN once its cause is deasserted.
REQ-025 MEMW: stall_if=stall_id=1, no flush, no issue, pending/out_cnt retain state except WB clears; branch_taken is ignored (EX holds it until the stall drops).
REQ-026 FLUSH (entered on branch_taken): flush_if_id=flush_id_ex=1 in the branch_taken cycle only; the ID instruction is killed, with no pending set and no count change; FLUSH->RUN after exactly one cycle.
REQ-027 HAZ: stall_if=stall_id=1, flush_id_ex=1 (bubble), flush_if_id=0.
REQ-028 Outputs are combinational from the FSM state and current inputs; the decode to outputs SHALL be consistent in the cycle the cause is first seen.

Reset
REQ-029 During rst: pending=0, out_cnt=0, err=0, state=RUN, issue=0, and all stall/flush outputs 0.
REQ-030 rst asserted mid-stall or mid-flush SHALL abandon the operation; the next cycle behaves as after power-up.

Structure
REQ-031 Shared package holds: FSM state enum, REG_AW=6, FP_BIT=5, default MAX_OUT.
REQ-032 One sub-module, scoreboard_regs: the 64-bit pending vector with set/clear ports and combinational three-address lookup.

Verification
REQ-033 LOAD rd=5 issued, next instruction reads rs1=5 -> HAZ, issue=0 until wb_valid rd=5; issue=1 in that same WB cycle.
REQ-034 FLW to rd=35 (f3), then an ADD reading rs2=3 -> no hazard, issue=1 (separate register files).
REQ-035 Four id_long issues with no WB, fifth id_long -> stall; a simultaneous wb_long releases it with out_cnt staying 4.
REQ-036 branch_taken while id_valid=1 and a hazard is pending -> flush_if_id=flush_id_ex=1 for 1 cycle, issue=0, pending unchanged.
REQ-037 dmem_stall for 3 cycles with branch_taken=1 -> stall_if=stall_id=1, no flush; flush occurs in the cycle after dmem_stall drops.
REQ-038 rst for 1 cycle while out_cnt=2 in MEMW -> out_cnt=0, pending=0, err=0, RUN; wb_long afterwards -> err=1.
